// File: rtl/conv16_psum_accum_pkg.sv
// Shared types and helpers for the conv16 partial-sum accumulator.
// Bank and read-side state encodings plus the ReLU/saturation rule.
package conv16_psum_accum_pkg;

  localparam int unsigned conv16_width = 8;

  typedef enum logic [1:0] {
    FREE,
    FILL,
    FULL,
    DRAIN
  } bank_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_OUT
  } rd_state_e;

  // Clamp a signed value into [0, 2^dw-1]; callers keep the low dw bits.
  function automatic logic [31:0] relu_sat(input logic signed [63:0] v,
                                           input int unsigned        dw);
    logic signed [63:0] maxv;
    maxv = (64'sd1 <<< dw) - 64'sd1;
    if (v < 64'sd0) begin
      relu_sat = '0;
    end else if (v > maxv) begin
      relu_sat = maxv[31:0];
    end else begin
      relu_sat = v[31:0];
    end
  endfunction

endpackage

// File: rtl/conv16_acc_bank.sv
// One accumulator bank: NOUT x ACCW signed register file with an
// init-or-add write port and an asynchronous read port.
module conv16_acc_bank
  import conv16_psum_accum_pkg::*;
#(
  parameter int unsigned NOUT = 8,
  parameter int unsigned ACCW = 20,
  parameter int unsigned IW   = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic                   wr_init,
  input  logic [IW-1:0]          wr_idx,
  input  logic signed [ACCW-1:0] wr_data,
  input  logic [IW-1:0]          rd_idx,
  output logic signed [ACCW-1:0] rd_data
);

  logic signed [ACCW-1:0] mem [NOUT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem <= '{default: '0};
    end else if (clr) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[wr_idx] <= wr_init ? wr_data : mem[wr_idx] + wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/conv16_psum_accum.sv
// Ping-pong partial-sum accumulator: sums KROWS row streams per column,
// then drains bias-added, shifted, ReLU-saturated results with handshake.
module conv16_psum_accum
  import conv16_psum_accum_pkg::*;
#(
  parameter int unsigned DW    = conv16_width,
  parameter int unsigned NOUT  = 8,
  parameter int unsigned KROWS = 3,
  parameter int unsigned ACCW  = 2 * DW + 4,
  parameter int unsigned SHIFT = DW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [2*DW-1:0] in_psum,
  input  logic [ACCW-1:0] bias,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [DW-1:0]   o_data,
  output logic            o_last,
  output logic            o_ovf
);

  localparam int unsigned CW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int unsigned RW = (KROWS > 1) ? $clog2(KROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(NOUT - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(KROWS - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          wr_bank;
  logic          rd_bank;
  bank_state_e   bank_st  [2];
  bank_state_e   bank_nxt [2];
  rd_state_e     rd_st;
  rd_state_e     rd_st_nxt;
  logic [CW-1:0] idx;
  logic [CW-1:0] rd_idx;

  logic signed [ACCW-1:0] bias_q;
  logic signed [ACCW-1:0] psum_ext;
  logic signed [ACCW-1:0] rd_data [2];
  logic signed [ACCW-1:0] sum_b;
  logic signed [ACCW-1:0] shifted;
  logic [DW-1:0]          res_dw;

  logic hs;
  logic beat_last;
  logic wr_ok;
  logic wr_go;
  logic free_evt;
  logic load_evt;
  logic load_bank;

  assign psum_ext  = {{(ACCW - 2 * DW){in_psum[2*DW-1]}}, in_psum};
  assign hs        = o_valid && o_ready;
  assign beat_last = (row == ROW_LAST) && (col == COL_LAST);

  // A bank being released on this edge may be refilled on the same edge.
  assign wr_ok = (bank_st[wr_bank] == FREE) || (bank_st[wr_bank] == FILL) ||
                 (free_evt && (rd_bank == wr_bank));
  assign wr_go = in_valid && wr_ok;

  // ---------------- write side ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col     <= '0;
      row     <= '0;
      wr_bank <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (clr) begin
      col     <= '0;
      row     <= '0;
      wr_bank <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      if (in_valid && !wr_ok) begin
        o_ovf <= 1'b1;
      end
      if (wr_go) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row     <= '0;
            wr_bank <= ~wr_bank;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    conv16_acc_bank #(
      .NOUT (NOUT),
      .ACCW (ACCW),
      .IW   (CW)
    ) u_bank (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (clr),
      .wr_en   (wr_go && (wr_bank == 1'(g))),
      .wr_init (row == '0),
      .wr_idx  (col),
      .wr_data (psum_ext),
      .rd_idx  (rd_idx),
      .rd_data (rd_data[g])
    );
  end

  // Later updates take priority: a refill overrides a same-edge release.
  always_comb begin
    bank_nxt = bank_st;
    if (free_evt) begin
      bank_nxt[rd_bank] = FREE;
    end
    if (load_evt) begin
      bank_nxt[load_bank] = DRAIN;
    end
    if (wr_go) begin
      bank_nxt[wr_bank] = beat_last ? FULL : FILL;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
    end else if (clr) begin
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
    end else begin
      bank_st <= bank_nxt;
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_st <= R_IDLE;
    end else if (clr) begin
      rd_st <= R_IDLE;
    end else begin
      rd_st <= rd_st_nxt;
    end
  end

  always_comb begin
    rd_st_nxt = rd_st;
    case (rd_st)
      R_IDLE: begin
        if (bank_st[rd_bank] == FULL) begin
          rd_st_nxt = R_LOAD;
        end
      end
      R_LOAD: rd_st_nxt = R_OUT;
      R_OUT: begin
        if (hs && (idx == COL_LAST)) begin
          rd_st_nxt = (bank_st[~rd_bank] == FULL) ? R_LOAD : R_IDLE;
        end
      end
      default: rd_st_nxt = R_IDLE;
    endcase
  end

  // The read address looks one column ahead so the next result is ready
  // in the output register as soon as the current one is accepted.
  always_comb begin
    free_evt  = (rd_st == R_OUT) && hs && (idx == COL_LAST);
    load_evt  = ((rd_st == R_IDLE) && (bank_st[rd_bank] == FULL)) ||
                (free_evt && (bank_st[~rd_bank] == FULL));
    load_bank = (rd_st == R_IDLE) ? rd_bank : ~rd_bank;
    rd_idx    = (rd_st == R_OUT) ? idx + 1'b1 : '0;
  end

  // ---------------- requant datapath + output register ----------------
  assign sum_b   = rd_data[rd_bank] + bias_q;
  assign shifted = sum_b >>> SHIFT;
  assign res_dw  = DW'(relu_sat({{(64 - ACCW){shifted[ACCW-1]}}, shifted}, DW));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      idx     <= '0;
      rd_bank <= 1'b0;
      bias_q  <= '0;
    end else if (clr) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      idx     <= '0;
      rd_bank <= 1'b0;
      bias_q  <= '0;
    end else begin
      if (load_evt) begin
        bias_q <= bias;
      end
      case (rd_st)
        R_LOAD: begin
          o_valid <= 1'b1;
          o_data  <= res_dw;
          o_last  <= (COL_LAST == '0);
          idx     <= '0;
        end
        R_OUT: begin
          if (hs) begin
            if (idx == COL_LAST) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              rd_bank <= ~rd_bank;
            end else begin
              idx    <= idx + 1'b1;
              o_data <= res_dw;
              o_last <= ((idx + 1'b1) == COL_LAST);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv16_psum_accum.sv
// Bench for conv16_psum_accum: directed cases plus randomized traffic
// checked against a queue-based model of the accumulate/requant rules.
module tb_conv16_psum_accum;

  localparam int DW    = 8;
  localparam int NOUT  = 8;
  localparam int KROWS = 3;
  localparam int ACCW  = 2 * DW + 4;
  localparam int SHIFT = DW;
  localparam int PSW   = 2 * DW;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic [PSW-1:0]  in_psum = '0;
  logic [ACCW-1:0] bias = '0;
  logic            o_valid;
  logic            o_ready = 1'b0;
  logic [DW-1:0]   o_data;
  logic            o_last;
  logic            o_ovf;

  always #5 clk = ~clk;

  conv16_psum_accum #(
    .DW    (DW),
    .NOUT  (NOUT),
    .KROWS (KROWS),
    .ACCW  (ACCW),
    .SHIFT (SHIFT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .in_valid (in_valid),
    .in_psum  (in_psum),
    .bias     (bias),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_last   (o_last),
    .o_ovf    (o_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int data;
    bit last;
  } beat_t;

  beat_t  exp_q [$];
  beat_t  got_q [$];
  longint msum [NOUT];
  int     mrow  = 0;
  int     mcol  = 0;
  longint mbias = 0;
  bit     sb_en = 1'b0;

  function automatic longint wrapw(input longint x);
    longint m;
    m = x & ((longint'(1) << ACCW) - 1);
    if (m >= (longint'(1) << (ACCW - 1))) m = m - (longint'(1) << ACCW);
    return m;
  endfunction

  function automatic int requant(input longint s, input longint b);
    longint v;
    v = wrapw(s + b) >>> SHIFT;
    if (v < 0) return 0;
    if (v > (1 << DW) - 1) return (1 << DW) - 1;
    return int'(v);
  endfunction

  task automatic model_beat(input int psum);
    beat_t e;
    if (mrow == 0) msum[mcol] = psum;
    else           msum[mcol] = wrapw(msum[mcol] + psum);
    mcol++;
    if (mcol == NOUT) begin
      mcol = 0;
      mrow++;
      if (mrow == KROWS) begin
        mrow = 0;
        for (int c = 0; c < NOUT; c++) begin
          e.data = requant(msum[c], mbias);
          e.last = (c == NOUT - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic model_reset();
    mrow = 0;
    mcol = 0;
    exp_q.delete();
  endtask

  task automatic set_bias(input longint b);
    bias  = ACCW'(b);
    mbias = b;
  endtask

  // One clock of stimulus; called 1ns after a rising edge.
  task automatic step(input bit v, input int psum, input bit rdy);
    in_valid = v;
    in_psum  = PSW'(psum);
    o_ready  = rdy;
    if (v) model_beat(psum);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    o_ready  = 1'b1;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || o_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic check_run(input string name, input int nbanks, input int v0, input int v1);
    check({name, "_count"}, got_q.size(), nbanks * NOUT);
    for (int i = 0; i < got_q.size() && i < nbanks * NOUT; i++) begin
      check($sformatf("%s_data%0d", name, i), got_q[i].data, (i < NOUT) ? v0 : v1);
      check($sformatf("%s_last%0d", name, i), got_q[i].last, (i % NOUT) == NOUT - 1);
    end
  endtask

  // ---------------- compare process ----------------
  bit            pv_en    = 1'b0;
  bit            pv_stall = 1'b0;
  logic [DW-1:0] pv_data  = '0;
  logic          pv_last  = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    beat_t g;
    if (rstn && o_valid && o_ready) begin
      g.data = int'(o_data);
      g.last = o_last;
      got_q.push_back(g);
    end
    if (sb_en) begin
      check("ovf_clear", o_ovf, 0);
      if (pv_en && pv_stall) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, pv_data);
        check("hold_last", o_last, pv_last);
      end
      if (o_valid && o_ready) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", o_data, e.data);
          check("out_last", o_last, e.last);
        end
      end
    end
    pv_en    = sb_en;
    pv_stall = o_valid && !o_ready;
    pv_data  = o_data;
    pv_last  = o_last;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit last_stall;
    int psum;
    bit v;
    bit rdy;

    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_last", o_last, 0);
    check("rst_o_ovf", o_ovf, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    sb_en = 1'b1;

    // uniform 256 psums: 768 >>> 8 = 3, plus first-output latency
    got_q.delete();
    set_bias(0);
    for (int i = 0; i < NOUT * KROWS; i++) step(1'b1, 256, 1'b1);
    @(negedge clk); check("lat_edge1", o_valid, 0);
    @(negedge clk); check("lat_edge2", o_valid, 0);
    @(negedge clk); check("lat_edge3", o_valid, 1);
    drain(100);
    check_run("t1", 1, 3, 3);

    // ReLU floor and saturation
    got_q.delete();
    for (int i = 0; i < NOUT * KROWS; i++) step(1'b1, -100, 1'b1);
    drain(100);
    check_run("t2_relu", 1, 0, 0);
    got_q.delete();
    for (int i = 0; i < NOUT * KROWS; i++) step(1'b1, 30000, 1'b1);
    drain(100);
    check_run("t2_sat", 1, 255, 255);

    // bias 512 sampled at load; later bias changes must not matter
    got_q.delete();
    set_bias(512);
    for (int i = 0; i < NOUT * KROWS; i++) step(1'b1, 0, 1'b0);
    for (int n = 0; n < 10 && !o_valid; n++) step(1'b0, 0, 1'b0);
    check("t3_valid_seen", o_valid, 1);
    step(1'b0, 0, 1'b0);
    bias = ACCW'(-4096);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    drain(100);
    check_run("t3", 1, 2, 2);
    set_bias(0);

    // 10-cycle o_ready stall mid-drain while the next bank keeps filling
    got_q.delete();
    for (int i = 0; i < NOUT * KROWS; i++)
      step(1'b1, int'($urandom_range(0, 4000)) - 2000, 1'b1);
    for (int k = 0; k < NOUT * KROWS; k++)
      step(1'b1, int'($urandom_range(0, 4000)) - 2000, !(k >= 4 && k < 14));
    drain(100);
    check("t4_count", got_q.size(), 2 * NOUT);

    // randomized traffic; o_ready never stalls two cycles in a row
    for (int ph = 0; ph < 3; ph++) begin
      set_bias(int'($urandom_range(0, 4000)) - 2000);
      last_stall = 1'b0;
      for (int c = 0; c < 300; c++) begin
        v = ($urandom_range(0, 9) < 6);
        if (ph == 0) psum = int'($urandom_range(0, 65535)) - 32768;
        else         psum = int'($urandom_range(0, 6000)) - 3000;
        rdy = last_stall ? 1'b1 : ($urandom_range(0, 3) != 0);
        last_stall = !rdy;
        step(v, psum, rdy);
      end
      drain(200);
    end

    // overflow: two banks stuck behind a stalled output, third bank dropped
    sb_en = 1'b0;
    set_bias(0);
    clr = 1'b1;
    step(1'b0, 0, 1'b0);
    clr = 1'b0;
    model_reset();
    got_q.delete();
    for (int i = 0; i < NOUT * KROWS; i++) step(1'b1, 256, 1'b0);
    for (int i = 0; i < NOUT * KROWS; i++) step(1'b1, 512, 1'b0);
    check("t5_ovf_before", o_ovf, 0);
    check("t5_valid_stalled", o_valid, 1);
    check("t5_data_stalled", o_data, 3);
    step(1'b1, 1000, 1'b0);
    check("t5_ovf_set", o_ovf, 1);
    for (int i = 1; i < NOUT * KROWS; i++) step(1'b1, 1000, 1'b0);
    check("t5_data_hold", o_data, 3);
    for (int n = 0; n < 60 && got_q.size() < 2 * NOUT; n++) step(1'b0, 0, 1'b1);
    check_run("t5", 2, 3, 6);
    check("t5_ovf_sticky", o_ovf, 1);
    clr = 1'b1;
    step(1'b0, 0, 1'b1);
    clr = 1'b0;
    check("t5_clr_ovf", o_ovf, 0);
    check("t5_clr_valid", o_valid, 0);

    // reset mid-operation discards all partial state
    for (int i = 0; i < NOUT * KROWS; i++) step(1'b1, 256, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b1, 256, 1'b0);
    check("t6_pre_valid", o_valid, 1);
    rstn = 1'b0;
    #2;
    check("t6_rst_valid", o_valid, 0);
    check("t6_rst_data", o_data, 0);
    check("t6_rst_last", o_last, 0);
    check("t6_rst_ovf", o_ovf, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    got_q.delete();
    sb_en = 1'b1;
    for (int i = 0; i < NOUT * KROWS; i++) step(1'b1, 256, 1'b1);
    drain(100);
    check_run("t6", 1, 3, 3);

    sb_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
